// File: rtl/prod_accum_pkg.sv
// Shared types and helpers for the product accumulator.
package prod_accum_pkg;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Batch index width: clog2 of the batch length, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prod_accum_sat_add.sv
// Unsigned saturating adder; carry flags that the result was clamped.
module sat_add #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b};
        carry = full[W];
        sum   = full[W] ? {W{1'b1}} : full[W-1:0];
    end

endmodule

// File: rtl/prod_accum.sv
// Batches COUNT_N products into a saturating sum and hands it off on a valid/ready port.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int unsigned PROD_W  = 8,
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned COUNT_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [7:0]        batch_cnt
);

    localparam int unsigned       IDX_W    = idx_width(COUNT_N);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(COUNT_N - 1);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [IDX_W-1:0]   idx;
    logic               ovf;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic               accept;
    logic               handoff;

    assign prod_ext = ACC_W'(in_prod);
    assign accept   = in_valid & in_ready;
    assign handoff  = out_valid & out_ready;

    sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .a     (acc),
        .b     (prod_ext),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // in_ready/out_valid are registered alongside the state so they mirror it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            idx       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            batch_cnt <= '0;
        end else if (clear) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            idx       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        if (idx == IDX_LAST) begin
                            out_sum   <= add_sum;
                            out_ovf   <= ovf | add_carry;
                            acc       <= '0;
                            idx       <= '0;
                            ovf       <= 1'b0;
                            state     <= ST_HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            acc <= add_sum;
                            ovf <= ovf | add_carry;
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (handoff) begin
                        state     <= ST_ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        batch_cnt <= batch_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= ST_ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// Directed and randomized checks for prod_accum at ACC_W=12 and ACC_W=9 in lockstep.
module tb_prod_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_prod;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf;
    logic [11:0] out_sum;
    logic [7:0]  batch_cnt;

    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [8:0]  s_out_sum;
    logic [7:0]  s_batch_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prod_accum #(.PROD_W(8), .ACC_W(12), .COUNT_N(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .batch_cnt(batch_cnt)
    );

    prod_accum #(.PROD_W(8), .ACC_W(9), .COUNT_N(4)) dut9 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_prod(in_prod),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sum(s_out_sum), .out_ovf(s_out_ovf), .batch_cnt(s_batch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one product and hold it until an edge where it is accepted.
    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_prod  = v;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_prod  = 8'hxx;
    endtask

    initial begin
        int          handoffs;
        int          cycles;
        int          msum;
        int          midx;
        int          mcnt;
        logic        do_acc;
        logic        do_ho;
        int          exp12;
        int          exp9;
        logic        expovf9;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_batch_cnt", 32'(batch_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Basic batch with a ready consumer.
        out_ready = 1'b1;
        send(8'd10); send(8'd20); send(8'd30); send(8'd40);
        chk("b1_out_valid", 32'(out_valid), 32'd1);
        chk("b1_out_sum",   32'(out_sum),   32'd100);
        chk("b1_out_ovf",   32'(out_ovf),   32'd0);
        chk("b1_in_ready",  32'(in_ready),  32'd0);
        tick();
        chk("b1_valid_drop", 32'(out_valid), 32'd0);
        chk("b1_batch_cnt",  32'(batch_cnt), 32'd1);

        // Backpressure, and saturation on the 9-bit instance.
        out_ready = 1'b0;
        send(8'd225); send(8'd225); send(8'd225); send(8'd225);
        chk("sat9_sum", 32'(s_out_sum), 32'd511);
        chk("sat9_ovf", 32'(s_out_ovf), 32'd1);
        chk("bp_ovf12", 32'(out_ovf),   32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_out_sum",   32'(out_sum),   32'd900);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_batch_cnt", 32'(batch_cnt), 32'd2);
        chk("bp_valid_drop", 32'(out_valid), 32'd0);

        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        chk("sat9_next_sum", 32'(s_out_sum), 32'd4);
        chk("sat9_next_ovf", 32'(s_out_ovf), 32'd0);
        tick();
        chk("b3_batch_cnt", 32'(batch_cnt), 32'd3);

        // Clear mid-batch; the product presented with clear is not taken.
        send(8'd50); send(8'd60);
        clear = 1'b1; in_valid = 1'b1; in_prod = 8'd99;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        chk("clr_out_sum",   32'(out_sum),   32'd10);
        chk("clr_batch_cnt", 32'(batch_cnt), 32'd3);
        tick();
        chk("clr_handoff_cnt", 32'(batch_cnt), 32'd4);

        // Clear while holding drops the output without counting it.
        out_ready = 1'b0;
        send(8'd5); send(8'd5); send(8'd5); send(8'd5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrh_out_valid", 32'(out_valid), 32'd0);
        chk("clrh_in_ready",  32'(in_ready),  32'd1);
        chk("clrh_batch_cnt", 32'(batch_cnt), 32'd4);

        // Async reset in the middle of HOLD, between clock edges.
        send(8'd7); send(8'd7); send(8'd7); send(8'd7);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_sum",   32'(out_sum),   32'd0);
        chk("arst_batch_cnt", 32'(batch_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Random gaps against a transaction-level model over 1000 batches.
        handoffs = 0; cycles = 0; msum = 0; midx = 0; mcnt = 0;
        exp12 = 0; exp9 = 0; expovf9 = 1'b0;
        while (handoffs < 1000 && cycles < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_prod   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) != 0);
            do_acc = in_valid & in_ready;
            do_ho  = out_valid & out_ready;
            if (do_ho) begin
                chk("rnd_sum12", 32'(out_sum),   32'(exp12));
                chk("rnd_sum9",  32'(s_out_sum), 32'(exp9));
                chk("rnd_ovf9",  32'(s_out_ovf), 32'(expovf9));
                chk("rnd_cnt",   32'(batch_cnt), 32'(mcnt % 256));
                mcnt++;
                handoffs++;
            end
            if (do_acc) begin
                msum += int'(in_prod);
                if (midx == 3) begin
                    exp12   = (msum > 4095) ? 4095 : msum;
                    exp9    = (msum > 511) ? 511 : msum;
                    expovf9 = (msum > 511);
                    msum = 0;
                    midx = 0;
                end else begin
                    midx++;
                end
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        chk("rnd_handoffs",  32'(handoffs),  32'd1000);
        chk("rnd_final_cnt", 32'(batch_cnt), 32'd232);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
